seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream consumer of the 32-bit segment-display PIO output port.
//  Takes packed hex nibbles and time-multiplexes them onto a common-segment, per-digit-enable 7-segment bank.
//  Shadows input once per scan frame (no mid-frame tearing), inserts anti-ghost blanking, decodes hex to segments.
// PARAMETERS
//  NUM_DIGITS    8      digits driven, 1..8; digit 0 = rightmost = nibble [3:0]
//  REFRESH_DIV   50000  clk cycles per digit slot, >= 2
//  BLANK_CYCLES  16     cycles at slot start with all digits disabled; must be < REFRESH_DIV
// PORTS
//  clk         in   1             system clock
//  reset       in   1             synchronous, active-high reset
//  digits_in   in   4*NUM_DIGITS  packed hex digits, connect to PIO out_port[4*NUM_DIGITS-1:0]
//  dp_in       in   NUM_DIGITS    decimal-point request per digit, 1 = lit
//  seg_n       out  7             segments {g,f,e,d,c,b,a}, active-low
//  dp_n        out  1             decimal point, active-low
//  dig_en_n    out  NUM_DIGITS    digit enables, active-low, at most one low
//  frame_done  out  1             1-cycle pulse on the cycle the shadow registers load
// BEHAVIOUR
//  Clocking: single clk domain; reset sampled only on rising clk.
//  Reset values: presc=0, idx=0, shadow digits=0, shadow dp=0;
//    seg_n=7'h7F, dp_n=1, dig_en_n=all 1, frame_done=0.
//  Prescaler presc counts 0..REFRESH_DIV-1, wraps to 0; idx increments when presc==REFRESH_DIV-1.
//  idx wraps NUM_DIGITS-1 -> 0; same cycle: shadow <= {digits_in, dp_in}, frame_done <= 1.
//  Frame period = NUM_DIGITS*REFRESH_DIV cycles; frame_done exactly once per frame.
//  First frame after reset displays shadow=0 (all '0', or blanked per LZB option).
//  Inputs changing mid-frame: no effect until the next idx wrap.
//  Outputs registered, 1-cycle latency from (presc, idx, shadow):
//    presc < BLANK_CYCLES -> dig_en_n all 1, seg_n=7'h7F, dp_n=1.
//    else dig_en_n[idx]=0, seg_n=decode(shadow nibble idx), dp_n=~shadow_dp[idx].
//  Hex decode table (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//    8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Reset asserted mid-frame: next edge forces all reset values; scan restarts at idx 0, presc 0.
//  idx width = clog2(NUM_DIGITS) (min 1); presc width = clog2(REFRESH_DIV); no overflow paths.
// CONFIGURATION
//  Macro SEG7_LEADING_ZERO_BLANK_EN:
//    defined: digit i>0 blanked (seg_n=7'h7F, dp_n from dp bit, enable still asserted)
//      if shadow nibble i and all higher nibbles are 0; digit 0 never blanked.
//    undefined: every digit decoded; zeros shown as 7'h40.
// STRUCTURE
//  Package seg7_pkg: SEG_OFF=7'h7F constant, 16-entry hex-to-segment table function, seg vector typedef.
//  Sub-module seg7_hex_decode: combinational nibble -> seg_n, used once on the muxed nibble.
//  Top holds prescaler, idx counter, shadow regs, blank mask, output registers.
// TESTING (bench params NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; frame = 32 cycles)
//  Reset held 3 cycles -> seg_n=7F, dp_n=1, dig_en_n=F, frame_done=0 throughout and 1 cycle after.
//  digits_in=16'h1234 before first wrap -> next frame: slot0 dig_en_n=E seg_n=19, slot1 D/30, slot2 B/24, slot3 7/79.
//  Change digits_in to 16'hABCD at cycle 40 -> display stays 1234 until frame_done at cycle 63, then shows ABCD.
//  Any slot -> dig_en_n=F for first 2 cycles, single low bit for remaining 6; frame_done spacing exactly 32.
//  digits_in=16'h0050, dp_in=4'b0010 -> with macro: digits 3,2 seg 7F, digit1 seg 12 dp_n 0, digit0 seg 40;
//    without macro: digits 3,2 show 40.
//  Reset pulsed at cycle 45 (mid slot 1) -> next cycle all outputs at reset values; after release idx=0 and
//    display shows 0000 (40 on each digit) until first frame_done.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;

  // Segment vector {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Hex nibble to active-low segment pattern.
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_n_o
);

  assign seg_n_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver. Shadows the packed hex input once per frame,
// blanks all digits for the first BLANK_CYCLES of each slot, and registers all outputs.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output seg_t                    seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PrescLast = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BlankEnd  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IdxLast   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] shadow_dig_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  seg_t                    seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   dig_en_n_q, dig_en_n_d;
  logic                    frame_done_q;

  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic                    lz_sel;
  logic [NUM_DIGITS-1:0]   en_sel;
  logic [NUM_DIGITS-1:0]   lz_blank;
  seg_t                    dec_seg;

  // Prescaler and digit index; wrap marks the last cycle of a frame.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (presc_q == PrescLast) begin
      presc_d = '0;
      if (idx_q == IdxLast) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_above;

  // A digit above 0 is blank when it and every higher nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above & (shadow_dig_q[4*i +: 4] == 4'h0);
      if (i > 0) lz_blank[i] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Select the current digit's nibble, dp bit, blank flag and enable pattern.
  always_comb begin
    nib_sel = '0;
    dp_sel  = 1'b0;
    lz_sel  = 1'b0;
    en_sel  = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        nib_sel   = shadow_dig_q[4*i +: 4];
        dp_sel    = shadow_dp_q[i];
        lz_sel    = lz_blank[i];
        en_sel[i] = 1'b0;
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nib_i   (nib_sel),
    .seg_n_o (dec_seg)
  );

  // Next output values: all dark during the anti-ghost window at slot start.
  always_comb begin
    seg_n_d    = SEG_OFF;
    dp_n_d     = 1'b1;
    dig_en_n_d = '1;
    if (!(presc_q < BlankEnd)) begin
      dig_en_n_d = en_sel;
      seg_n_d    = lz_sel ? SEG_OFF : dec_seg;
      dp_n_d     = ~dp_sel;
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      seg_n_q      <= SEG_OFF;
      dp_n_q       <= 1'b1;
      dig_en_n_q   <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      dig_en_n_q   <= dig_en_n_d;
      frame_done_q <= wrap;
      if (wrap) begin
        shadow_dig_q <= digits_in;
        shadow_dp_q  <= dp_in;
      end
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign dig_en_n   = dig_en_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// Each frame's expected content is queued when the inputs are driven and checked per cycle
// when the frame is displayed.
module tb_seg7_scan_driver;

  localparam int unsigned NumDigits   = 4;
  localparam int unsigned RefreshDiv  = 8;
  localparam int unsigned BlankCycles = 2;
  localparam int unsigned FrameLen    = NumDigits * RefreshDiv;

  localparam logic [6:0] HexSeg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  dig_en_n;
  logic        frame_done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  frame_t      sb_q [$];

  seg7_scan_driver #(
    .NUM_DIGITS   (NumDigits),
    .REFRESH_DIV  (RefreshDiv),
    .BLANK_CYCLES (BlankCycles)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_en_n   (dig_en_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg"}, 16'(seg_n), 16'h7F);
    check_eq({tag, "_dp"}, 16'(dp_n), 16'h1);
    check_eq({tag, "_en"}, 16'(dig_en_n), 16'hF);
    check_eq({tag, "_fd"}, 16'(frame_done), 16'h0);
  endtask

  // Checks one full frame of samples, starting on the negedge after the frame's first edge.
  task automatic check_frame();
    frame_t     f;
    int         slot;
    int         p;
    logic [3:0] nib;
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       lz;
    f = '0;
    check_eq("sb_nonempty", 16'(sb_q.size() != 0), 16'h1);
    if (sb_q.size() != 0) f = sb_q.pop_front();
    for (int m = 0; m < int'(FrameLen); m++) begin
      @(negedge clk);
      slot = m / int'(RefreshDiv);
      p    = m % int'(RefreshDiv);
      if (p < int'(BlankCycles)) begin
        exp_en  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_en = ~(4'b0001 << slot);
        nib    = 4'((f.dig >> (4 * slot)) & 16'hF);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz = (slot > 0) && ((f.dig >> (4 * slot)) == 16'h0);
`else
        lz = 1'b0;
`endif
        exp_seg = lz ? 7'h7F : HexSeg[nib];
        exp_dp  = ~f.dp[slot];
      end
      check_eq("dig_en_n", 16'(dig_en_n), 16'(exp_en));
      check_eq("seg_n", 16'(seg_n), 16'(exp_seg));
      check_eq("dp_n", 16'(dp_n), 16'(exp_dp));
      check_eq("frame_done", 16'(frame_done), 16'(m == int'(FrameLen) - 1));
    end
  endtask

  initial begin
    reset     = 1'b1;
    digits_in = 16'h0;
    dp_in     = 4'h0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end

    reset     = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    sb_q.push_back('{dig: 16'h0000, dp: 4'b0000});
    sb_q.push_back('{dig: 16'h1234, dp: 4'b0000});

    fork
      begin
        repeat (5) check_frame();
      end
      begin
        // Mid-frame changes; each only appears after the following frame_done.
        repeat (40) @(negedge clk);
        digits_in = 16'hABCD;
        sb_q.push_back('{dig: 16'hABCD, dp: 4'b0000});
        repeat (32) @(negedge clk);
        digits_in = 16'h0050;
        dp_in     = 4'b0010;
        sb_q.push_back('{dig: 16'h0050, dp: 4'b0010});
        repeat (32) @(negedge clk);
        digits_in = 16'h7E60;
        dp_in     = 4'b1000;
        sb_q.push_back('{dig: 16'h7E60, dp: 4'b1000});
      end
    join

    // Reset mid slot 1; shadow must return to zero regardless of inputs.
    digits_in = 16'h9999;
    dp_in     = 4'b1111;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    sb_q.push_back('{dig: 16'h0000, dp: 4'b0000});
    check_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout t=%0t got=running expected=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
